// File: rtl/any1_agen_seq.sv
// Sequential address generator for the ANY-1 memory pipeline: one request in,
// a stream of scaled-index, strided or descending push addresses out.
//
// state | meaning
// IDLE  | waiting for a request; req_ready_o high
// EMIT  | presenting addresses on ma_o until the last one is taken
module any1_agen_seq #(
  parameter int unsigned AMSB  = 63,
  parameter int unsigned ELEW  = 6,
  parameter int unsigned PSTEP = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      mode_i,
  input  logic [AMSB:0]   base_i,
  input  logic [AMSB:0]   a_i,
  input  logic [AMSB:0]   b_i,
  input  logic [AMSB:0]   disp_i,
  input  logic [2:0]      scale_i,
  input  logic [ELEW:0]   cnt_i,
  output logic            ma_valid_o,
  input  logic            ma_ready_i,
  output logic [AMSB:0]   ma_o,
  output logic [ELEW-1:0] ele_o,
  output logic            last_o,
  input  logic            abort_i,
  output logic            busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [1:0] M_STRIDED = 2'd1;
  localparam logic [1:0] M_PUSH    = 2'd2;

  localparam logic [AMSB:0] PSTEP_W = (AMSB+1)'(PSTEP);

  logic [0:0]      state;
  logic [AMSB:0]   acc;
  logic [AMSB:0]   stride;
  logic [ELEW:0]   rem;
  logic [ELEW-1:0] ele;

  logic [2:0]      sh;
  logic [AMSB:0]   acc_ld;
  logic [AMSB:0]   stride_ld;
  logic [ELEW:0]   cnt_eff;

  assign sh = (scale_i > 3'd4) ? 3'd0 : scale_i;

  // Reserved mode 3 falls into the scaled-index default.
  always_comb begin
    acc_ld    = base_i + a_i + disp_i + (b_i << sh);
    stride_ld = '0;
    cnt_eff   = (ELEW+1)'(1);
    case (mode_i)
      M_STRIDED: begin
        acc_ld    = base_i + a_i + disp_i;
        stride_ld = b_i;
        cnt_eff   = cnt_i;
      end
      M_PUSH: begin
        acc_ld    = base_i + a_i - PSTEP_W;
        stride_ld = '0 - PSTEP_W;
        cnt_eff   = cnt_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      acc    <= '0;
      stride <= '0;
      rem    <= '0;
      ele    <= '0;
    end else if (abort_i) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      // A zero-count request is consumed without touching the output registers.
      if (req_valid_i && (cnt_eff != '0)) begin
        acc    <= acc_ld;
        stride <= stride_ld;
        rem    <= cnt_eff;
        ele    <= '0;
        state  <= EMIT;
      end
    end else if (ma_ready_i) begin
      acc <= acc + stride;
      ele <= ele + 1'b1;
      rem <= rem - 1'b1;
      if (rem == (ELEW+1)'(1)) state <= IDLE;
    end
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state == EMIT);
  assign ma_valid_o  = (state == EMIT);
  assign ma_o        = acc;
  assign ele_o       = ele;
  assign last_o      = (state == EMIT) && (rem == (ELEW+1)'(1));

endmodule

// File: tb/tb_any1_agen_seq.sv
// Directed and randomized bench for any1_agen_seq; expected address streams
// come from closed-form start + k*stride arithmetic.
module tb_any1_agen_seq;

  localparam int AMSB  = 63;
  localparam int ELEW  = 6;
  localparam int PSTEP = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [1:0]      mode_i = '0;
  logic [AMSB:0]   base_i = '0;
  logic [AMSB:0]   a_i = '0;
  logic [AMSB:0]   b_i = '0;
  logic [AMSB:0]   disp_i = '0;
  logic [2:0]      scale_i = '0;
  logic [ELEW:0]   cnt_i = '0;
  logic            ma_valid_o;
  logic            ma_ready_i = 1'b0;
  logic [AMSB:0]   ma_o;
  logic [ELEW-1:0] ele_o;
  logic            last_o;
  logic            abort_i = 1'b0;
  logic            busy_o;

  int tests = 0;
  int fails = 0;

  logic [63:0] expq[$];

  any1_agen_seq #(.AMSB(AMSB), .ELEW(ELEW), .PSTEP(PSTEP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .mode_i(mode_i), .base_i(base_i), .a_i(a_i), .b_i(b_i),
    .disp_i(disp_i), .scale_i(scale_i), .cnt_i(cnt_i),
    .ma_valid_o(ma_valid_o), .ma_ready_i(ma_ready_i),
    .ma_o(ma_o), .ele_o(ele_o), .last_o(last_o),
    .abort_i(abort_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the address list a request should produce.
  task automatic model(input logic [1:0] m, input logic [63:0] base, a, b, disp,
                       input logic [2:0] sc, input int cnt);
    int sh;
    int n;
    expq.delete();
    sh = (sc <= 3'd4) ? int'(sc) : 0;
    n  = (m == 2'd1 || m == 2'd2) ? cnt : 1;
    for (int k = 0; k < n; k++) begin
      if (m == 2'd1)      expq.push_back(base + a + disp + 64'(k) * b);
      else if (m == 2'd2) expq.push_back(base + a - 64'(PSTEP) * 64'(k + 1));
      else                expq.push_back(base + a + disp + b * (64'd1 << sh));
    end
  endtask

  task automatic do_req(input logic [1:0] m, input logic [63:0] base, a, b, disp,
                        input logic [2:0] sc, input int cnt);
    @(negedge clk_i);
    model(m, base, a, b, disp, sc, cnt);
    req_valid_i = 1'b1;
    mode_i = m; base_i = base; a_i = a; b_i = b; disp_i = disp;
    scale_i = sc; cnt_i = (ELEW+1)'(cnt);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    chk("busy_after_accept", {63'd0, busy_o}, {63'd0, expq.size() != 0});
  endtask

  // rmode: 0 always ready, 1 random, 2 fixed pattern 1,0,1,1,0,1
  task automatic drain(input string tag, input int rmode);
    int n;
    int k;
    int cyc;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    n = expq.size();
    k = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      @(negedge clk_i);
      if (rmode == 0)      ma_ready_i = 1'b1;
      else if (rmode == 1) ma_ready_i = 1'($urandom_range(0, 1));
      else                 ma_ready_i = pat[cyc % 6];
      chk({tag, "_valid"}, {63'd0, ma_valid_o}, 64'd1);
      chk({tag, "_addr"}, ma_o, expq[k]);
      chk({tag, "_ele"}, 64'(ele_o), 64'(k));
      chk({tag, "_last"}, {63'd0, last_o}, {63'd0, k == n - 1});
      if (ma_ready_i) k++;
      cyc++;
    end
    chk({tag, "_done"}, 64'(k), 64'(n));
    @(negedge clk_i);
    ma_ready_i = 1'b0;
    chk({tag, "_idle_valid"}, {63'd0, ma_valid_o}, 64'd0);
    chk({tag, "_idle_ready"}, {63'd0, req_ready_o}, 64'd1);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_valid", {63'd0, ma_valid_o}, 64'd0);
    chk("rst_ma", ma_o, 64'd0);
    chk("rst_ele", 64'(ele_o), 64'd0);
    chk("rst_last", {63'd0, last_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Scaled: 0x1000 + 0x20 - 8 + (3<<3) = 0x1030
    do_req(2'd0, 64'h1000, 64'h20, 64'd3, -64'sd8, 3'd3, 0);
    chk("scaled_model", expq[0], 64'h1030);
    drain("scaled", 0);

    // Strided with backpressure
    do_req(2'd1, 64'h0, 64'h100, 64'h40, 64'h0, 3'd0, 4);
    drain("strided_bp", 2);

    // Push with wrap
    do_req(2'd2, 64'h0, 64'h10, 64'h0, 64'h0, 3'd0, 3);
    chk("push_model", expq[2], 64'hFFFF_FFFF_FFFF_FFE0);
    drain("push_wrap", 0);

    // Zero count strided, then scaled one cycle later
    do_req(2'd1, 64'h500, 64'h5, 64'h8, 64'h0, 3'd0, 0);
    chk("cnt0_valid", {63'd0, ma_valid_o}, 64'd0);
    chk("cnt0_ready", {63'd0, req_ready_o}, 64'd1);
    do_req(2'd3, 64'h2000, 64'h4, 64'h7, 64'h1, 3'd6, 0);
    drain("after_cnt0_mode3", 0);

    // Full-size count: element index reaches 2^ELEW-1
    do_req(2'd1, 64'hABC0, 64'h0, 64'h8, 64'h0, 3'd0, 64);
    drain("cnt_max", 1);

    // Abort on second element with a concurrent request
    do_req(2'd1, 64'h0, 64'h800, 64'h10, 64'h0, 3'd0, 8);
    @(negedge clk_i);
    ma_ready_i = 1'b1;
    chk("abort_e0", ma_o, expq[0]);
    @(negedge clk_i);
    chk("abort_e1", ma_o, expq[1]);
    chk("abort_e1_ele", 64'(ele_o), 64'd1);
    abort_i = 1'b1;
    req_valid_i = 1'b1;
    mode_i = 2'd0; cnt_i = '0;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    req_valid_i = 1'b0;
    chk("abort_valid", {63'd0, ma_valid_o}, 64'd0);
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_ready", {63'd0, req_ready_o}, 64'd1);
    @(posedge clk_i);
    #1;
    chk("abort_no_accept", {63'd0, ma_valid_o}, 64'd0);
    ma_ready_i = 1'b0;

    // Asynchronous reset mid-emission
    do_req(2'd1, 64'h40, 64'h40, 64'h4, 64'h0, 3'd0, 5);
    @(negedge clk_i);
    ma_ready_i = 1'b1;
    @(posedge clk_i);
    #2;
    chk("pre_rst_valid", {63'd0, ma_valid_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ma_valid_o}, 64'd0);
    chk("arst_ma", ma_o, 64'd0);
    chk("arst_ele", 64'(ele_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ma_ready_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("post_rst_ma", ma_o, 64'd0);

    // Randomized requests
    for (int r = 0; r < 30; r++) begin
      logic [1:0]  m;
      logic [63:0] rb, ra, rbb, rd;
      logic [2:0]  rs;
      int          rc;
      m   = 2'($urandom_range(0, 3));
      rb  = {$urandom, $urandom};
      ra  = {$urandom, $urandom};
      rbb = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      rs  = 3'($urandom_range(0, 7));
      rc  = (r % 7 == 3) ? 0 : int'($urandom_range(1, 64));
      do_req(m, rb, ra, rbb, rd, rs, rc);
      if (expq.size() == 0) begin
        chk("rand_cnt0_valid", {63'd0, ma_valid_o}, 64'd0);
      end else begin
        drain("rand", 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/any1_agen_seq.md
# any1_agen_seq

Sequential, parametrised address generator for the ANY-1 out-of-order core's memory pipeline. It accepts one address-generation request per operation and emits a stream of effective addresses, one per element, through a valid/ready handshake. Supported patterns are scaled-index (single address), strided vector and descending push sequences. It sits between the issue stage and the load/store queue, and replaces per-element re-issue of strided and push operations.

## Interface
Parameters:
- AMSB, 63: MSB of address; all address datapaths are AMSB+1 bits.
- ELEW, 6: element-index width; max element count is 2^ELEW.
- PSTEP, 16: byte decrement per push element.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- mode_i  in  2  0 = SCALED, 1 = STRIDED, 2 = PUSH, 3 = reserved (treated as SCALED).
- base_i  in  AMSB+1  segment/base address.
- a_i  in  AMSB+1  base register value.
- b_i  in  AMSB+1  index (SCALED) or stride (STRIDED).
- disp_i  in  AMSB+1  sign-extended displacement, already formed by decode.
- scale_i  in  3  index shift 0..4; values 5..7 mean shift 0.
- cnt_i  in  ELEW+1  element count for STRIDED/PUSH, 0..2^ELEW.
- ma_valid_o  out  1  ma_o/ele_o/last_o valid.
- ma_ready_i  in  1  consumer takes the current address.
- ma_o  out  AMSB+1  effective address.
- ele_o  out  ELEW  element index of ma_o.
- last_o  out  1  ma_o is the final address of the request.
- abort_i  in  1  synchronous flush (pipeline flush or branch miss).
- busy_o  out  1  a request is in progress.

## Operation
- States: IDLE, EMIT.
- req_ready_o = (state == IDLE); busy_o = (state == EMIT). Both are derived from registered state only.
- Accept: req_valid_i & req_ready_o at a rising edge. The block latches the operands and loads the address accumulator:
  - SCALED: base+a+disp+(b<<s). Count forced to 1.
  - STRIDED: base+a+disp. Remaining count = cnt_i.
  - PUSH: base+a-PSTEP. Remaining count = cnt_i.
- If the effective count is 0 (STRIDED/PUSH with cnt_i = 0), the block stays in IDLE. Nothing is emitted and the request is consumed.
- EMIT: ma_valid_o = 1. ma_o = accumulator. ele_o = element counter. last_o = (remaining == 1).
- Handshake (ma_valid_o & ma_ready_i):
  - Accumulator += stride. Stride is b for STRIDED and -PSTEP for PUSH. No multiplier is used.
  - Element counter +1, remaining -1.
  - If last_o is set, go to IDLE.
- Without a handshake, ma_o, ele_o and last_o hold stable.
- All arithmetic is modulo 2^(AMSB+1). Wrap-around is silent, with no fault or flag.
- abort_i has priority over both the handshake and accept. At the edge where abort_i is high, state goes to IDLE and ma_valid_o drops. A request presented in the same cycle as abort_i is not accepted.
- mode 3 behaves exactly as SCALED.

## Timing
- Reset (rst_ni low, asynchronous) values:
  - state = IDLE, so req_ready_o = 1, busy_o = 0.
  - ma_valid_o = 0, ma_o = 0, ele_o = 0, last_o = 0.
- Latency: a request accepted at edge T produces its first address with ma_valid_o = 1 in the cycle after T.
- Throughput: one address per cycle while ma_ready_i is held high.
- No overlap between requests. The final handshake at edge T returns the block to IDLE. The earliest next accept is edge T+1, so there is one bubble per request.
- Reset asserted mid-EMIT: outputs return to reset values immediately; no element is completed.
- Count 2^ELEW: the element counter reaches 2^ELEW-1 on the last element. ele_o never wraps within a request.

## Test plan
- Reset and idle: assert rst_ni low mid-sequence -> ma_valid_o drops asynchronously; after release, req_ready_o = 1 and ma_o = 0.
- SCALED: base=0x1000, a=0x20, disp=-8, b=3, scale=3 -> one address 0x1030 with ele_o = 0 and last_o = 1, one cycle after accept. Then req_ready_o returns to 1.
- STRIDED with backpressure: base=0, a=0x100, disp=0, b=0x40, cnt=4, ma_ready_i toggling 1,0,1,1,0,1 -> addresses 0x100, 0x140, 0x180, 0x1C0 with ele_o 0..3, held while not ready, and last_o only on 0x1C0.
- PUSH with wrap: base=0, a=0x10, cnt=3 -> addresses 0x0, 0xFFFF_FFFF_FFFF_FFF0, 0xFFFF_FFFF_FFFF_FFE0 (AMSB=63).
- cnt=0 STRIDED, followed by a SCALED request -> no ma_valid_o for the first request; the second is accepted one cycle later and emits normally.
- abort_i on the 2nd element of a cnt=8 STRIDED request, while req_valid_i is high -> ma_valid_o = 0 next cycle, the concurrent request is not accepted, and req_ready_o = 1 afterwards.
